// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int BYTE_W          = 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, wrapping.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] winner
);

  int unsigned idx;

  // Scan from lowest priority to highest so the last hit is the nearest one after ptr.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int unsigned i = N; i > 0; i--) begin
      idx = (32'(ptr) + i) % N;
      if (req[idx]) begin
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter among NUM_REQ byte requesters.
// Optional UART_ARB_LOCK_EN adds req_lock to keep a multi-byte frame on one requester.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk_50m,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        ack,
  output logic                      tx_en,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active
);

  arb_state_t           state, state_nxt;
  logic [ID_W-1:0]      ptr;
  logic [NUM_REQ-1:0]   cand;
  logic                 pick_any;
  logic [ID_W-1:0]      pick_id;
  logic                 grant;

`ifdef UART_ARB_LOCK_EN
  logic                 lock_on;
  logic [ID_W-1:0]      lock_id;
  logic                 lock_hold;

  // A lock only restricts candidates while its owner still asserts req_lock.
  assign lock_hold = lock_on && req_lock[lock_id];

  always_comb begin
    cand = req;
    if (lock_hold) begin
      cand          = '0;
      cand[lock_id] = req[lock_id];
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      lock_on <= 1'b0;
      lock_id <= '0;
    end else if (state == S_WAIT_DONE && !tx_busy) begin
      lock_on <= req_lock[grant_id];
      lock_id <= grant_id;
    end else if (state == S_IDLE && lock_on && !req_lock[lock_id]) begin
      lock_on <= 1'b0;
    end
  end
`else
  assign cand = req;
`endif

  rr_pick #(
    .N (NUM_REQ),
    .W (ID_W)
  ) u_pick (
    .req    (cand),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_id)
  );

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Idle also waits out tx_busy so a reset during a byte cannot overlap a new load.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    tx_en     = 1'b0;
    ack       = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_any && !tx_busy) begin
          grant     = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        tx_en         = 1'b1;
        ack[grant_id] = 1'b1;
        state_nxt     = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign active = (state != S_IDLE);

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      ptr      <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      tx_data  <= '0;
    end else begin
      if (grant) begin
        grant_id <= pick_id;
        tx_data  <= req_data[BYTE_W*pick_id +: BYTE_W];
      end
      if (state == S_LOAD) begin
        ptr <= grant_id;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: arbiter driving a behavioural 8N1 transmitter with clken every 16 cycles.
module tb_uart_tx_arbiter;

  logic        clk_50m  = 1'b0;
  logic        rst      = 1'b0;
  logic [3:0]  req      = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy  = 1'b0;
  logic [1:0]  grant_id;
  logic        active;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  req_lock = '0;
  int          lock_left[4];
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] clk_div     = '0;
  logic       clken;
  logic       line        = 1'b1;
  logic [7:0] sh          = '0;
  int         bitn        = 0;
  int         overlap_cnt = 0;
  logic       bits_q[$];
  logic [7:0] rx_q[$];
  int         ack_log[$];
  int         cnt[4];
  int         didx[4];
  int         ack_cnt[4];
  logic [7:0] dseq[4][4];

  always #10 clk_50m = ~clk_50m;
  assign clken = (clk_div == 4'd15);

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk_50m  (clk_50m),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
`ifdef UART_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .ack      (ack),
    .tx_en    (tx_en),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .grant_id (grant_id),
    .active   (active)
  );

  // Transmitter: busy from the cycle after load until the stop bit starts; start waits for clken.
  always @(posedge clk_50m) begin
    clk_div <= clk_div + 4'd1;
    if (tx_en && tx_busy) overlap_cnt <= overlap_cnt + 1;
    if (tx_en && !tx_busy) begin
      sh      <= tx_data;
      tx_busy <= 1'b1;
      bitn    <= 0;
    end else if (tx_busy && clken) begin
      if (bitn == 0) begin
        line <= 1'b0;
        bits_q.push_back(1'b0);
      end else if (bitn <= 8) begin
        line <= sh[bitn-1];
        bits_q.push_back(sh[bitn-1]);
      end else begin
        line    <= 1'b1;
        bits_q.push_back(1'b1);
        rx_q.push_back(sh);
        tx_busy <= 1'b0;
      end
      bitn <= bitn + 1;
    end
  end

  task automatic step();
    @(negedge clk_50m);
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        ack_log.push_back(i);
        ack_cnt[i]++;
        didx[i]++;
        if (cnt[i] > 0) cnt[i]--;
        if (cnt[i] == 0) req[i] = 1'b0;
        else req_data[8*i +: 8] = dseq[i][didx[i]];
`ifdef UART_ARB_LOCK_EN
        if (lock_left[i] > 0) begin
          lock_left[i]--;
          if (lock_left[i] == 0) req_lock[i] = 1'b0;
        end
`endif
      end
    end
  endtask

  task automatic post(input int i, input int n, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2);
    dseq[i][0] = d0;
    dseq[i][1] = d1;
    dseq[i][2] = d2;
    dseq[i][3] = 8'h00;
    cnt[i]  = n;
    didx[i] = 0;
    req_data[8*i +: 8] = d0;
    req[i] = 1'b1;
  endtask

  task automatic run_until(input int nbytes, input int budget, input string name);
    int c = 0;
    while (!(rx_q.size() >= nbytes && !tx_busy && !active) && c < budget) begin
      step();
      c++;
    end
    n_vec++;
    if (!(rx_q.size() >= nbytes && !tx_busy && !active)) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d bytes, required %0d", name, rx_q.size(), nbytes);
    end
  endtask

  task automatic wait_busy(input int budget, input string name);
    int c = 0;
    while (!tx_busy && c < budget) begin
      step();
      c++;
    end
    n_vec++;
    if (tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_busy_timeout: tx_busy=%b, required 1", name, tx_busy);
    end
  endtask

  task automatic reset_dut();
    int c = 0;
    while (tx_busy && c < 400) begin
      @(negedge clk_50m);
      c++;
    end
    req = '0;
`ifdef UART_ARB_LOCK_EN
    req_lock = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      didx[i] = 0;
      ack_cnt[i] = 0;
`ifdef UART_ARB_LOCK_EN
      lock_left[i] = 0;
`endif
    end
    rst = 1'b1;
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst = 1'b0;
    bits_q.delete();
    rx_q.delete();
    ack_log.delete();
  endtask

  task automatic test_reset();
    #5 rst = 1'b1;
    #1;
    n_vec++;
    if ({tx_en, ack, active, grant_id, tx_data} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_outputs: tx_en=%b ack=%b active=%b grant_id=%0d tx_data=%h, required all 0",
               tx_en, ack, active, grant_id, tx_data);
    end
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst = 1'b0;
    @(negedge clk_50m);
    n_vec++;
    if (active !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: active=%b, required 0", active);
    end
  endtask

  task automatic test_single();
    logic [9:0] got;
    logic [9:0] exp_bits;
    exp_bits = 10'b1_10100101_0;
    reset_dut();
    @(posedge clk_50m);
    #1;
    post(2, 1, 8'hA5, 8'h00, 8'h00);
    @(negedge clk_50m);
    n_vec++;
    if (tx_en !== 1'b0) begin
      n_err++;
      $display("FAIL single_early_tx_en: tx_en=%b, required 0", tx_en);
    end
    @(negedge clk_50m);
    n_vec++;
    if ({tx_en, ack, grant_id, tx_data} !== {1'b1, 4'b0100, 2'd2, 8'hA5}) begin
      n_err++;
      $display("FAIL single_load: tx_en=%b ack=%b grant_id=%0d tx_data=%h, required 1 0100 2 a5",
               tx_en, ack, grant_id, tx_data);
    end
    ack_cnt[2] = 1;
    cnt[2] = 0;
    req[2] = 1'b0;
    run_until(1, 600, "single");
    got = '0;
    for (int i = 0; i < 10 && i < bits_q.size(); i++) got[i] = bits_q[i];
    n_vec++;
    if (bits_q.size() != 10 || got !== exp_bits) begin
      n_err++;
      $display("FAIL single_serial: %0d bits %b (bit0 first from right), required 10 bits %b",
               bits_q.size(), got, exp_bits);
    end
    n_vec++;
    if (ack_cnt[2] != 1) begin
      n_err++;
      $display("FAIL single_ack_count: %0d acks, required 1", ack_cnt[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[5];
    int         exp_id[5];
    int         ov0;
    exp_b  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_id = '{0, 1, 2, 3, 0};
    reset_dut();
    ov0 = overlap_cnt;
    post(0, 2, 8'h11, 8'h11, 8'h00);
    post(1, 1, 8'h22, 8'h00, 8'h00);
    post(2, 1, 8'h33, 8'h00, 8'h00);
    post(3, 1, 8'h44, 8'h00, 8'h00);
    run_until(5, 2500, "b2b");
    for (int k = 0; k < 5; k++) begin
      n_vec++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k] || k >= ack_log.size() || ack_log[k] != exp_id[k]) begin
        n_err++;
        $display("FAIL b2b_order[%0d]: byte %h from req %0d, required %h from req %0d", k,
                 (k < rx_q.size()) ? rx_q[k] : 8'hxx, (k < ack_log.size()) ? ack_log[k] : -1,
                 exp_b[k], exp_id[k]);
      end
    end
    n_vec++;
    if (overlap_cnt != ov0) begin
      n_err++;
      $display("FAIL b2b_overlap: %0d loads while busy, required 0", overlap_cnt - ov0);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_b[4];
    exp_b = '{8'hA1, 8'h3C, 8'hA2, 8'hA3};
    reset_dut();
    post(1, 3, 8'hA1, 8'hA2, 8'hA3);
    wait_busy(100, "rot");
    repeat (5) step();
    post(3, 1, 8'h3C, 8'h00, 8'h00);
    run_until(4, 2500, "rot");
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin
        n_err++;
        $display("FAIL rot_order[%0d]: byte %h, required %h", k,
                 (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int ov0;
    int early;
    int c;
    reset_dut();
    ov0 = overlap_cnt;
    post(1, 1, 8'h81, 8'h00, 8'h00);
    post(2, 1, 8'hC3, 8'h00, 8'h00);
    wait_busy(100, "rstmid");
    repeat (20) step();
    n_vec++;
    if (tx_busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy: tx_busy=%b, required 1", tx_busy);
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({tx_en, ack, active, grant_id, tx_data} !== 16'h0000) begin
      n_err++;
      $display("FAIL rstmid_outputs: tx_en=%b ack=%b active=%b grant_id=%0d tx_data=%h, required all 0",
               tx_en, ack, active, grant_id, tx_data);
    end
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst = 1'b0;
    early = 0;
    c = 0;
    while (tx_busy && c < 400) begin
      step();
      if (active) early++;
      c++;
    end
    n_vec++;
    if (early != 0) begin
      n_err++;
      $display("FAIL rstmid_early_grant: active for %0d busy cycles, required 0", early);
    end
    run_until(2, 1000, "rstmid");
    n_vec++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h81 || rx_q[1] !== 8'hC3) begin
      n_err++;
      $display("FAIL rstmid_frames: %0d bytes first %h, required 2 bytes 81 c3",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    n_vec++;
    if (overlap_cnt != ov0 || ack_cnt[2] != 1) begin
      n_err++;
      $display("FAIL rstmid_load: overlaps %0d acks[2] %0d, required 0 and 1",
               overlap_cnt - ov0, ack_cnt[2]);
    end
  endtask

  task automatic test_drop_before_grant();
    reset_dut();
    post(2, 1, 8'h10, 8'h00, 8'h00);
    wait_busy(100, "drop");
    post(0, 1, 8'h55, 8'h00, 8'h00);
    post(1, 1, 8'h66, 8'h00, 8'h00);
    repeat (10) step();
    n_vec++;
    if (tx_busy !== 1'b1 || active !== 1'b1) begin
      n_err++;
      $display("FAIL drop_still_busy: tx_busy=%b active=%b, required 1 1", tx_busy, active);
    end
    req[0] = 1'b0;
    cnt[0] = 0;
    run_until(2, 1000, "drop");
    n_vec++;
    if (ack_cnt[0] != 0) begin
      n_err++;
      $display("FAIL drop_ack0: %0d acks, required 0", ack_cnt[0]);
    end
    n_vec++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h10 || rx_q[1] !== 8'h66) begin
      n_err++;
      $display("FAIL drop_bytes: %0d bytes last %h, required 2 bytes 10 66",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[rx_q.size()-1] : 8'hxx);
    end
  endtask

`ifdef UART_ARB_LOCK_EN
  task automatic test_lock();
    logic [7:0] exp_b[4];
    exp_b = '{8'hD0, 8'hD1, 8'hD2, 8'hE0};
    reset_dut();
    post(0, 3, 8'hD0, 8'hD1, 8'hD2);
    post(1, 1, 8'hE0, 8'h00, 8'h00);
    req_lock[0]  = 1'b1;
    lock_left[0] = 3;
    run_until(4, 2500, "lock");
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (k >= rx_q.size() || rx_q[k] !== exp_b[k]) begin
        n_err++;
        $display("FAIL lock_order[%0d]: byte %h, required %h", k,
                 (k < rx_q.size()) ? rx_q[k] : 8'hxx, exp_b[k]);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rotation();
    test_reset_mid_byte();
    test_drop_before_grant();
`ifdef UART_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
